// File: rtl/uart_tx_fifo.sv
// UART transmitter with an on-block TX FIFO, run-time divisor and stop-bit count.
// Optional parity bit when UART_TX_PARITY_EN is defined (adds par_en / par_odd ports).
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic [DIV_W-1:0]           div,
  input  logic                       stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                       par_en,
  input  logic                       par_odd,
`endif
  output logic                       txd,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  // state    | meaning
  // S_IDLE   | line high, waiting for a queued byte
  // S_START  | start bit (low) for one bit period
  // S_DATA   | DATA_W data bits, LSB first
  // S_PARITY | optional parity bit
  // S_STOP   | one or two stop bits (high)
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [LW-1:0]     level_n;
  logic              push, pop, full;
  logic [DATA_W-1:0] head;

  state_t            state, state_n;
  logic [DIV_W-1:0]  tick, tick_n, div_l, div_l_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              stop2_l, stop2_l_n, stop_cnt, stop_cnt_n;
  logic              txd_n, load, tick_done;
`ifdef UART_TX_PARITY_EN
  logic              par_en_l, par_en_l_n, par_bit, par_bit_n;
`endif

  assign full     = (level == LW'(DEPTH));
  assign wr_ready = ~full;
  assign push     = wr_valid & ~full;
  assign head     = mem[rptr];

  always_comb begin
    level_n = level;
    case ({push, pop})
      2'b10:   level_n = level + LW'(1);
      2'b01:   level_n = level - LW'(1);
      default: level_n = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      level <= level_n;
    end
  end

  assign tick_done = (tick == div_l);

  always_comb begin
    state_n    = state;
    tick_n     = tick;
    div_l_n    = div_l;
    bit_cnt_n  = bit_cnt;
    sh_n       = sh;
    stop2_l_n  = stop2_l;
    stop_cnt_n = stop_cnt;
    txd_n      = txd;
    load       = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_l_n = par_en_l;
    par_bit_n  = par_bit;
`endif
    case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        load  = (level != '0);
      end
      S_START: begin
        if (tick_done) begin
          tick_n    = '0;
          txd_n     = sh[0];
          sh_n      = {1'b0, sh[DATA_W-1:1]};
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end else begin
          tick_n = tick + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (tick_done) begin
          tick_n = '0;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_cnt_n  = '0;
            txd_n      = 1'b1;
            stop_cnt_n = 1'b0;
            state_n    = S_STOP;
`ifdef UART_TX_PARITY_EN
            if (par_en_l) begin
              txd_n   = par_bit;
              state_n = S_PARITY;
            end
`endif
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
            txd_n     = sh[0];
            sh_n      = {1'b0, sh[DATA_W-1:1]};
          end
        end else begin
          tick_n = tick + DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_done) begin
          tick_n     = '0;
          txd_n      = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = S_STOP;
        end else begin
          tick_n = tick + DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick_done) begin
          tick_n = '0;
          if (stop2_l && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else if (level != '0) begin
            load = 1'b1;
          end else begin
            txd_n   = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          tick_n = tick + DIV_W'(1);
        end
      end
      default: begin
        txd_n   = 1'b1;
        state_n = S_IDLE;
      end
    endcase

    // Frame start: pop the head and freeze the run-time settings for this frame.
    if (load) begin
      pop       = 1'b1;
      sh_n      = head;
      div_l_n   = (div == '0) ? DIV_W'(1) : div;
      stop2_l_n = stop2;
      tick_n    = '0;
      txd_n     = 1'b0;
      state_n   = S_START;
`ifdef UART_TX_PARITY_EN
      par_en_l_n = par_en;
      par_bit_n  = par_odd ? ~^head : ^head;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick     <= '0;
      div_l    <= DIV_W'(1);
      bit_cnt  <= '0;
      sh       <= '0;
      stop2_l  <= 1'b0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_l <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      div_l    <= div_l_n;
      bit_cnt  <= bit_cnt_n;
      sh       <= sh_n;
      stop2_l  <= stop2_l_n;
      stop_cnt <= stop_cnt_n;
      txd      <= txd_n;
      busy     <= (state_n != S_IDLE) | (level_n != '0);
`ifdef UART_TX_PARITY_EN
      par_en_l <= par_en_l_n;
      par_bit  <= par_bit_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: framing, back-to-back frames, full FIFO, stop bits,
// divisor latching, reset abort, and parity when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [15:0] div;
  logic        stop2;
  logic        txd;
  logic        busy;
  logic [4:0]  level;
`ifdef UART_TX_PARITY_EN
  logic        par_en;
  logic        par_odd;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .DIV_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .div      (div),
    .stop2    (stop2),
`ifdef UART_TX_PARITY_EN
    .par_en   (par_en),
    .par_odd  (par_odd),
`endif
    .txd      (txd),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write1(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  // Expected line level for bit slot pos of an 8N frame: start, 8 data LSB first, stop.
  function automatic logic fbit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  initial begin
    logic [7:0] bytes2 [3];
    int  acc;
    logic saw_low;

    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; div = 16'd3; stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en = 1'b0; par_odd = 1'b0;
`endif
    do_reset();
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_level", level, 0);
    chk("reset_wr_ready", wr_ready, 1);

    // 1: single 0xA5 frame, div=3
    write1(8'hA5);
    chk("t1_level_after_write", level, 1);
    chk("t1_busy_after_write", busy, 1);
    for (int j = 0; j < 40; j++) begin
      tick();
      chk($sformatf("t1_txd_%0d", j), txd, fbit(8'hA5, j / 4));
    end
    chk("t1_busy_last_stop", busy, 1);
    tick();
    chk("t1_busy_done", busy, 0);
    chk("t1_txd_idle", txd, 1);

    // 2: three bytes on consecutive edges, back-to-back frames
    bytes2[0] = 8'h01; bytes2[1] = 8'h02; bytes2[2] = 8'h03;
    wr_valid = 1'b1; wr_data = 8'h01;
    tick();
    chk("t2_level_w1", level, 1);
    wr_data = 8'h02;
    tick();
    chk("t2_txd_0", txd, 0);
    wr_data = 8'h03;
    tick();
    wr_valid = 1'b0;
    chk("t2_level_peak", level, 2);
    chk("t2_txd_1", txd, 0);
    for (int j = 2; j < 120; j++) begin
      tick();
      chk($sformatf("t2_txd_%0d", j), txd, fbit(bytes2[j / 40], (j % 40) / 4));
    end
    tick();
    chk("t2_busy_done", busy, 0);

    // 3: stall with a huge divisor and overfill the FIFO
    do_reset();
    div = 16'hFFFF;
    acc = 0;
    wr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'(i);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    chk("t3_accepts", acc, 17);
    chk("t3_level_full", level, 16);
    chk("t3_wr_ready_low", wr_ready, 0);
    chk("t3_txd_start", txd, 0);

    // 4: two stop bits, div=1; settings changed mid-frame must not apply
    do_reset();
    div = 16'd1; stop2 = 1'b1;
    write1(8'hFF);
    for (int j = 0; j < 22; j++) begin
      tick();
      if (j == 0) begin
        div = 16'd0; stop2 = 1'b0;
      end
      chk($sformatf("t4_txd_%0d", j), txd, (j < 2) ? 1'b0 : 1'b1);
    end
    chk("t4_busy_in_stop2", busy, 1);
    tick();
    chk("t4_busy_done", busy, 0);

    // 4b: div=0 behaves as div=1 (2 clocks per bit), one stop bit
    write1(8'h00);
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("t4b_txd_%0d", j), txd, (j < 18) ? 1'b0 : 1'b1);
    end
    chk("t4b_busy_last", busy, 1);
    tick();
    chk("t4b_busy_done", busy, 0);

    // 5: reset mid-DATA with five bytes queued
    div = 16'd3; stop2 = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("t5_level_queued", level, 5);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_txd_after_rst", txd, 1);
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_level_after_rst", level, 0);
    chk("t5_wr_ready_after_rst", wr_ready, 1);
    saw_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    chk("t5_no_frames", saw_low, 0);
    chk("t5_busy_stays_low", busy, 0);

`ifdef UART_TX_PARITY_EN
    // 6: even and odd parity on 0x07
    for (int k = 0; k < 2; k++) begin
      par_en = 1'b1; par_odd = k[0]; div = 16'd3;
      write1(8'h07);
      for (int j = 0; j < 44; j++) begin
        logic e;
        tick();
        if (j / 4 == 0)      e = 1'b0;
        else if (j / 4 <= 8) e = (j / 4 <= 3);
        else if (j / 4 == 9) e = (k == 0);
        else                 e = 1'b1;
        chk($sformatf("t6_par%0d_txd_%0d", k, j), txd, e);
      end
      tick();
      chk($sformatf("t6_par%0d_busy_done", k), busy, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
